// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: run/pause/lap/clear FSM, BCD time counters,
// divider gating and lap-frozen display selection.
module stopwatch_controller #(
  parameter int MINUTE_LIMIT = 59,
  parameter bit LAP_ENABLE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       div_rst,
  output logic       running,
  output logic       lap_active,
  output logic       ovf,
  output logic [1:0] state,
  output logic [7:0] disp_cs,
  output logic [7:0] disp_s,
  output logic [7:0] disp_m
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } st_t;

  localparam logic [7:0] MLIM = {
    4'(MINUTE_LIMIT / 10),
    4'(MINUTE_LIMIT % 10)
  };

  st_t        st;
  logic [7:0] cs, s, m;
  logic [7:0] lcs, ls, lm;
  logic [7:0] cs_n, s_n, m_n;
  logic       counting, at_max, ovf_hit;
  logic       lap_go;

  function automatic logic [7:0] bcd_step(input logic [7:0] v);
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign state   = st;
  assign div_rst = ~rst | (st == IDLE) | (st == PAUSE);
  assign lap_go  = LAP_ENABLE & btn_lap;

  // Post-tick live value; holds at the limit so overflow never wraps
  always_comb begin
    counting = ((st == RUN) || (st == LAP)) && tick;
    at_max   = (cs == 8'h99) && (s == 8'h59) && (m == MLIM);
    ovf_hit  = counting && at_max;
    cs_n     = cs;
    s_n      = s;
    m_n      = m;
    if (counting && !at_max) begin
      if (cs == 8'h99) begin
        cs_n = 8'h00;
        if (s == 8'h59) begin
          s_n = 8'h00;
          m_n = bcd_step(m);
        end else begin
          s_n = bcd_step(s);
        end
      end else begin
        cs_n = bcd_step(cs);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= IDLE;
      cs         <= '0;
      s          <= '0;
      m          <= '0;
      lcs        <= '0;
      ls         <= '0;
      lm         <= '0;
      ovf        <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      disp_cs    <= '0;
      disp_s     <= '0;
      disp_m     <= '0;
    end else begin
      cs      <= cs_n;
      s       <= s_n;
      m       <= m_n;
      disp_cs <= cs_n;
      disp_s  <= s_n;
      disp_m  <= m_n;
      if (ovf_hit) begin
        ovf        <= 1'b1;
        st         <= PAUSE;
        running    <= 1'b0;
        lap_active <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            if (btn_start_stop) begin
              st      <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (btn_start_stop) begin
              st      <= PAUSE;
              running <= 1'b0;
            end else if (lap_go) begin
              st         <= LAP;
              lap_active <= 1'b1;
              lcs        <= cs_n;
              ls         <= s_n;
              lm         <= m_n;
            end
          end
          LAP: begin
            if (btn_start_stop) begin
              st         <= PAUSE;
              running    <= 1'b0;
              lap_active <= 1'b0;
            end else if (btn_lap) begin
              st         <= RUN;
              lap_active <= 1'b0;
            end else begin
              disp_cs <= lcs;
              disp_s  <= ls;
              disp_m  <= lm;
            end
          end
          PAUSE: begin
            if (btn_clear) begin
              st      <= IDLE;
              ovf     <= 1'b0;
              cs      <= '0;
              s       <= '0;
              m       <= '0;
              lcs     <= '0;
              ls      <= '0;
              lm      <= '0;
              disp_cs <= '0;
              disp_s  <= '0;
              disp_m  <= '0;
            end else if (btn_start_stop && !ovf) begin
              st      <= RUN;
              running <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
